// File: rtl/fmpadding_cfg_sched.sv
// Configuration scheduler for the fmpadding core: writes descriptors into the core's registers
// and opens the core's input only at frame boundaries. Optional frame counter: FMPADDING_SCHED_FRAME_CNT_EN.
module fmpadding_cfg_sched #(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 2,
    parameter int BEAT_BITS     = XCOUNTER_BITS + YCOUNTER_BITS + $clog2(NUM_CHANNELS / SIMD) + 1
) (
    input  logic                                       ap_clk,
    input  logic                                       ap_rst,
    input  logic                                       cfg_tvalid,
    output logic                                       cfg_tready,
    input  logic [3*XCOUNTER_BITS+3*YCOUNTER_BITS-1:0] cfg_tdata,
    output logic                                       we,
    output logic [4:0]                                 wa,
    output logic [31:0]                                wd,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    output logic                                       pad_tvalid,
    input  logic                                       pad_tready,
    input  logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       busy,
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
    output logic [31:0]                                frame_cnt,
`endif
    output logic                                       frame_done
);
    localparam int XB    = XCOUNTER_BITS;
    localparam int YB    = YCOUNTER_BITS;
    localparam int CFG_W = 3 * XB + 3 * YB;
    localparam int FOLD  = NUM_CHANNELS / SIMD;
    localparam logic [BEAT_BITS-1:0] ONE    = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] FOLD_B = BEAT_BITS'(FOLD);

    typedef enum logic [1:0] {IDLE, WRITE, RUN} state_t;

    state_t               state_q, state_d;
    logic [2:0]           wcnt_q, wcnt_d;
    logic [CFG_W-1:0]     act_q, act_d;
    logic [CFG_W-1:0]     pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [BEAT_BITS-1:0] in_beats_q, in_beats_d;
    logic [BEAT_BITS-1:0] out_beats_q, out_beats_d;
    logic [BEAT_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [BEAT_BITS-1:0] out_cnt_q, out_cnt_d;
    logic                 gate_q, gate_d;
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
    logic [31:0]          frame_cnt_q, frame_cnt_d;
`endif

    logic [XB-1:0] xon, xoff, xend;
    logic [YB-1:0] yon, yoff, yend;
    logic [BEAT_BITS-1:0] dx, dy, xe, ye, in_beats_c, out_beats_c;
    logic [31:0] wd_field;
    logic gate_open, cfg_hs, pad_hs, m_hs, last_out;

    assign xon  = act_q[XB-1:0];
    assign xoff = act_q[2*XB-1:XB];
    assign xend = act_q[3*XB-1:2*XB];
    assign yon  = act_q[3*XB+YB-1:3*XB];
    assign yoff = act_q[3*XB+2*YB-1:3*XB+YB];
    assign yend = act_q[3*XB+3*YB-1:3*XB+2*YB];

    // Inverted ON/OFF pairs give an empty window rather than a wrapped count.
    always_comb begin
        dx          = (xoff > xon) ? BEAT_BITS'(xoff - xon) : '0;
        dy          = (yoff > yon) ? BEAT_BITS'(yoff - yon) : '0;
        xe          = BEAT_BITS'(xend) + ONE;
        ye          = BEAT_BITS'(yend) + ONE;
        in_beats_c  = dx * dy * FOLD_B;
        out_beats_c = xe * ye * FOLD_B;
    end

    always_comb begin
        case (wcnt_q)
            3'd0:    wd_field = 32'(xon);
            3'd1:    wd_field = 32'(xoff);
            3'd2:    wd_field = 32'(xend);
            3'd3:    wd_field = 32'(yon);
            3'd4:    wd_field = 32'(yoff);
            3'd5:    wd_field = 32'(yend);
            default: wd_field = '0;
        endcase
    end

    // All outputs read idle during the reset cycle itself.
    assign gate_open = gate_q & ~ap_rst;
    assign cfg_hs    = cfg_tvalid & cfg_tready;
    assign pad_hs    = s_axis_tvalid & pad_tready & gate_open;
    assign m_hs      = m_axis_tvalid & m_axis_tready;
    assign last_out  = ~ap_rst & (state_q == RUN) & m_hs & (out_cnt_q == ONE);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            in_beats_q  <= '0;
            out_beats_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            gate_q      <= 1'b0;
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            in_beats_q  <= in_beats_d;
            out_beats_q <= out_beats_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            gate_q      <= gate_d;
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_hs) state_d = WRITE;
            WRITE:   if (wcnt_q == 3'd5) state_d = RUN;
            RUN:     if (last_out && (pend_vld_q || cfg_hs)) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        in_beats_d  = in_beats_q;
        out_beats_d = out_beats_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    act_d  = cfg_tdata;
                    wcnt_d = '0;
                end
            end
            WRITE: begin
                wcnt_d      = wcnt_q + 3'd1;
                in_beats_d  = in_beats_c;
                out_beats_d = out_beats_c;
                if (wcnt_q == 3'd5) begin
                    wcnt_d    = '0;
                    in_cnt_d  = in_beats_q;
                    out_cnt_d = out_beats_q;
                end
            end
            RUN: begin
                if (pad_hs && in_cnt_q != '0) in_cnt_d = in_cnt_q - ONE;
                if (m_hs && out_cnt_q != '0) out_cnt_d = out_cnt_q - ONE;
                if (cfg_hs) begin
                    pend_d     = cfg_tdata;
                    pend_vld_d = 1'b1;
                end
                // A descriptor arriving on the last beat goes straight to active.
                if (last_out) begin
                    if (pend_vld_q || cfg_hs) begin
                        act_d      = pend_vld_q ? pend_q : cfg_tdata;
                        pend_vld_d = 1'b0;
                        wcnt_d     = '0;
                    end else begin
                        in_cnt_d  = in_beats_q;
                        out_cnt_d = out_beats_q;
                    end
                end
            end
            default: ;
        endcase
        gate_d = (state_d == RUN) && (in_cnt_d != '0);
    end

`ifdef FMPADDING_SCHED_FRAME_CNT_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (last_out) frame_cnt_d = frame_cnt_q + 32'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif

    always_comb begin
        cfg_tready    = ~ap_rst & ((state_q == IDLE) | ((state_q == RUN) & ~pend_vld_q));
        we            = ~ap_rst & (state_q == WRITE);
        wa            = we ? 5'(wcnt_q) : 5'd0;
        wd            = we ? wd_field : 32'd0;
        busy          = ~ap_rst & (state_q != IDLE);
        frame_done    = last_out;
        s_axis_tready = pad_tready & gate_open;
        pad_tvalid    = s_axis_tvalid & gate_open;
    end
endmodule

// File: tb/tb_fmpadding_cfg_sched.sv
// Bench for fmpadding_cfg_sched: integer reference model checked every cycle, plus literal
// per-frame beat totals, write sequence and gate latency. Honours FMPADDING_SCHED_FRAME_CNT_EN.
module tb_fmpadding_cfg_sched;
    localparam int FOLD = 2;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        cfg_tvalid = 1'b0;
    logic        cfg_tready;
    logic [47:0] cfg_tdata = '0;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        pad_tvalid;
    logic        pad_tready = 1'b1;
    logic        m_axis_tvalid = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic        frame_done;
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
    logic [31:0] frame_cnt;
`endif

    always #5 ap_clk = ~ap_clk;

    fmpadding_cfg_sched #(
        .XCOUNTER_BITS(8), .YCOUNTER_BITS(8), .NUM_CHANNELS(4), .SIMD(2)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
        .we(we), .wa(wa), .wd(wd),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .pad_tvalid(pad_tvalid), .pad_tready(pad_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy),
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [47:0] mk(input int xon, xoff, xend, yon, yoff, yend);
        return {8'(yend), 8'(yoff), 8'(yon), 8'(xend), 8'(xoff), 8'(xon)};
    endfunction

    function automatic int fld(input logic [47:0] d, input int i);
        return int'((d >> (8 * i)) & 48'hff);
    endfunction

    function automatic int in_beats(input logic [47:0] d);
        int dx, dy;
        dx = (fld(d, 1) > fld(d, 0)) ? fld(d, 1) - fld(d, 0) : 0;
        dy = (fld(d, 4) > fld(d, 3)) ? fld(d, 4) - fld(d, 3) : 0;
        return dx * dy * FOLD;
    endfunction

    function automatic int out_beats(input logic [47:0] d);
        return (fld(d, 2) + 1) * (fld(d, 5) + 1) * FOLD;
    endfunction

    // Reference model: phase 0 idle, 1 writing registers, 2 running a frame.
    int          m_ph = 0, m_wr = 0, m_in = 0, m_out = 0, m_frames = 0;
    logic [47:0] m_act = '0, m_pend = '0;
    bit          m_pv = 0;

    always @(negedge ap_clk) begin
        bit e_rdy, e_gate, e_we, e_fd, e_busy, c_hs, p_hs, o_hs;
        int e_wa, e_wd;
        e_rdy = 0; e_gate = 0; e_we = 0; e_fd = 0; e_busy = 0; e_wa = 0; e_wd = 0;
        o_hs  = m_axis_tvalid && m_axis_tready;
        if (!ap_rst) begin
            e_rdy  = (m_ph == 0) || (m_ph == 2 && !m_pv);
            e_we   = (m_ph == 1);
            e_wa   = e_we ? m_wr : 0;
            e_wd   = e_we ? fld(m_act, m_wr) : 0;
            e_gate = (m_ph == 2) && (m_in > 0);
            e_fd   = (m_ph == 2) && o_hs && (m_out == 1);
            e_busy = (m_ph != 0);
        end
        chk("cfg_tready", cfg_tready, e_rdy);
        chk("we", we, e_we);
        chk("wa", wa, e_wa);
        chk("wd", wd, e_wd);
        chk("s_axis_tready", s_axis_tready, pad_tready & e_gate);
        chk("pad_tvalid", pad_tvalid, s_axis_tvalid & e_gate);
        chk("busy", busy, e_busy);
        chk("frame_done", frame_done, e_fd);
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, m_frames);
`endif
        c_hs = cfg_tvalid && e_rdy;
        p_hs = s_axis_tvalid && pad_tready && e_gate;
        if (ap_rst) begin
            m_ph = 0; m_pv = 0; m_wr = 0; m_in = 0; m_out = 0; m_frames = 0;
        end else begin
            case (m_ph)
                0: if (c_hs) begin m_act = cfg_tdata; m_ph = 1; m_wr = 0; end
                1: if (m_wr == 5) begin
                       m_ph = 2; m_in = in_beats(m_act); m_out = out_beats(m_act);
                   end else m_wr++;
                default: begin
                    if (p_hs && m_in > 0) m_in--;
                    if (c_hs) begin m_pend = cfg_tdata; m_pv = 1; end
                    if (e_fd) begin
                        m_frames++;
                        if (m_pv) begin
                            m_act = m_pend; m_pv = 0; m_ph = 1; m_wr = 0;
                        end else begin
                            m_in = in_beats(m_act); m_out = out_beats(m_act);
                        end
                    end else if (o_hs && m_out > 0) m_out--;
                end
            endcase
        end
    end

    // Observed per-frame beat totals, write log and first accept/gate timing.
    int fr_in[$], fr_out[$], wa_log[$], wd_log[$];
    int mon_in = 0, mon_out = 0, acc_cyc = -1, gate_cyc = -1;
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            mon_in = 0; mon_out = 0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) mon_in++;
            if (m_axis_tvalid && m_axis_tready && busy && !we) mon_out++;
            if (we) begin wa_log.push_back(int'(wa)); wd_log.push_back(int'(wd)); end
            if (acc_cyc < 0 && cfg_tvalid && cfg_tready) acc_cyc = cyc;
            if (gate_cyc < 0 && s_axis_tready) gate_cyc = cyc;
            if (frame_done) begin
                fr_in.push_back(mon_in); fr_out.push_back(mon_out);
                mon_in = 0; mon_out = 0;
            end
        end
    end

    task automatic send(input logic [47:0] d);
        bit got;
        got = 0;
        @(posedge ap_clk); #1;
        cfg_tdata = d; cfg_tvalid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge ap_clk);
            if (cfg_tready) got = 1;
        end
        chk("cfg_accept", got, 1);
        @(posedge ap_clk); #1;
        cfg_tvalid = 1'b0;
    endtask

    task automatic wait_fd(input int n, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge ap_clk);
            if (frame_done) seen++;
        end
        chk("frame_done_count", seen, n);
    endtask

    bit rnd_en = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d1, d2, d3;
        int exp_in[8], exp_out[8], nin;
        bit hit;
        d1 = mk(1, 3, 3, 1, 3, 3);
        d2 = mk(0, 2, 1, 0, 2, 1);
        d3 = mk(2, 2, 3, 1, 3, 3);
        exp_in  = '{8, 8, 8, 8, 0, 8, 8, 8};
        exp_out = '{32, 32, 8, 8, 32, 32, 32, 32};

        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        s_axis_tvalid = 1'b1; m_axis_tvalid = 1'b1;
        @(negedge ap_clk);
        chk("post_reset_cfg_tready", cfg_tready, 1);
        chk("post_reset_busy", busy, 0);

        // Frames 1-2: d1 twice; d2 queued mid-frame 2.
        send(d1);
        wait_fd(1, 200);
        repeat (10) @(posedge ap_clk);
        send(d2);
        @(negedge ap_clk);
        chk("pending_blocks_cfg", cfg_tready, 0);
        chk("pending_no_we", we, 0);
        wait_fd(1, 200);
        wait_fd(1, 200);
        // d3 has an empty input window; queued during frame 4.
        send(d3);
        wait_fd(1, 200);
        send(d1);
        wait_fd(1, 200);

        // Frame 6 (d1): reset after 5 input beats.
        nin = 0; hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge ap_clk);
            if (s_axis_tvalid && s_axis_tready) nin++;
            if (nin == 5) hit = 1;
        end
        chk("five_inputs_seen", hit, 1);
        @(posedge ap_clk); #1;
        s_axis_tvalid = 1'b0; ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_gate_closed", s_axis_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_tready", cfg_tready, 1);
        chk("rst_no_we", we, 0);
        s_axis_tvalid = 1'b1;

        // Three d1 frames with random backpressure on both sides.
        rnd_en = 1;
        fork
            while (rnd_en) begin
                @(posedge ap_clk); #1;
                if (rnd_en) begin
                    pad_tready    = 1'($urandom_range(0, 1));
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
            begin
                send(d1);
                wait_fd(3, 3000);
                rnd_en = 0;
            end
        join
        pad_tready = 1'b1; m_axis_tready = 1'b1;
`ifdef FMPADDING_SCHED_FRAME_CNT_EN
        @(negedge ap_clk);
        chk("frame_cnt_after_3", frame_cnt, 3);
`endif

        chk("accept_to_gate_cycles", gate_cyc - acc_cyc, 7);
        chk("write_log_size", wa_log.size() >= 6, 1);
        if (wa_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("first_wa", wa_log[i], i);
                chk("first_wd", wd_log[i], (i == 0 || i == 3) ? 1 : 3);
            end
        end
        chk("frame_list_size", fr_in.size(), 8);
        for (int i = 0; i < 8 && i < fr_in.size(); i++) begin
            chk("frame_in_beats", fr_in[i], exp_in[i]);
            chk("frame_out_beats", fr_out[i], exp_out[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
